// File: rtl/uart_fc.sv
// uart_fc: UART transceiver with RX/TX FIFOs and RTS/CTS hardware flow control.
// Frame: start bit, DATA_BITS data bits (LSB first), optional even parity, one stop bit.
// Optional feature macro: UART_PARITY_EN (adds the even-parity bit on TX and RX).
module uart_fc #(
    parameter int CLK_DIV    = 104,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic                 err_clr,
    output logic                 rx_overrun,
    output logic                 frame_err,
    output logic                 parity_err,
    input  logic                 uart_rx,
    input  logic                 uart_cts,
    output logic                 uart_tx,
    output logic                 uart_rts
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] MARGIN_P  = PW'(RTS_MARGIN);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE   = BW'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

`ifdef UART_PARITY_EN
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    // Synchronisers and line history
    logic rx_meta_q, rx_sync_q, rx_prev_q, cts_meta_q, cts_sync_q;

    // TX FIFO and TX FSM
    logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
    logic [PW-1:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_empty_s, tx_push_s, tx_pop_s;
    logic [DATA_BITS-1:0] tx_head_s;
    state_e               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_line_q, tx_line_d;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
    logic                 rx_perr_q, rx_perr_d;
`endif

    // RX FIFO and RX FSM
    logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
    logic [PW-1:0]        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_count_s;
    logic                 rx_valid_s, rx_full_s, rx_pop_s, rx_push_s, rx_ovf_s, rx_good_s;
    logic                 rx_overrun_q, rx_overrun_d, rts_q, rts_d;
    logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    state_e               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

    // Two-flop synchronisers for uart_rx / uart_cts, plus previous rx level for edge detect
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            cts_meta_q <= uart_cts;
            cts_sync_q <= cts_meta_q;
        end
    end

    // TX FIFO pointer arithmetic; tx_ready is registered from the post-update count
    always_comb begin
        tx_empty_s = (tx_wr_q == tx_rd_q);
        tx_head_s  = tx_mem_q[tx_rd_q[AW-1:0]];
        tx_push_s  = tx_valid && tx_ready_q;
        tx_wr_d    = tx_wr_q + PW'(tx_push_s);
        tx_rd_d    = tx_rd_q + PW'(tx_pop_s);
        tx_ready_d = ((tx_wr_d - tx_rd_d) < DEPTH_P);
    end

    // TX next state: the FIFO head is popped at the moment a frame is committed
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop_s   = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = CNT_ZERO;
                if (!tx_empty_s && !cts_sync_q) begin
                    tx_pop_s   = 1'b1;
                    tx_state_d = S_START;
                    tx_shift_d = tx_head_s;
`ifdef UART_PARITY_EN
                    tx_par_d   = even_parity(tx_head_s);
`endif
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = CNT_ZERO;
                    tx_bit_d   = BIT_ZERO;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                    if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        tx_state_d = S_PARITY;
`else
                        tx_state_d = S_STOP;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_ONE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_state_d = S_STOP;
                    tx_cnt_d   = CNT_ZERO;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (!tx_empty_s && !cts_sync_q) begin
                        tx_pop_s   = 1'b1;
                        tx_state_d = S_START;
                        tx_shift_d = tx_head_s;
`ifdef UART_PARITY_EN
                        tx_par_d   = even_parity(tx_head_s);
`endif
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // TX line level for the upcoming state, so uart_tx is a flop output
    always_comb begin
        tx_line_d = 1'b1;
        case (tx_state_d)
            S_IDLE:   tx_line_d = 1'b1;
            S_START:  tx_line_d = 1'b0;
            S_DATA:   tx_line_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_line_d = tx_par_d;
`endif
            S_STOP:   tx_line_d = 1'b1;
            default:  tx_line_d = 1'b1;
        endcase
    end

    // RX next state: start validated at half bit, then one sample per bit period
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
`ifdef UART_PARITY_EN
        rx_perr_d  = rx_perr_q;
`endif
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = CNT_ZERO;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = S_START;
                end else begin
                    rx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = CNT_ZERO;
                    rx_bit_d = BIT_ZERO;
                    if (rx_sync_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_d = S_PARITY;
`else
                        rx_state_d = S_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_ONE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_perr_d  = even_parity(rx_shift_q) ^ rx_sync_q;
                    rx_state_d = S_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                rx_state_d = S_IDLE;
                rx_cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // RX frame verdict at the stop-bit sample point
    always_comb begin
        if ((rx_state_q == S_STOP) && (rx_cnt_q == DIV_LAST)) begin
            frame_err_d = !rx_sync_q;
`ifdef UART_PARITY_EN
            parity_err_d = rx_perr_q;
            rx_good_s    = rx_sync_q && !rx_perr_q;
`else
            parity_err_d = 1'b0;
            rx_good_s    = rx_sync_q;
`endif
        end else begin
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
            rx_good_s    = 1'b0;
        end
    end

    // RX FIFO control: a same-cycle pop makes room on a full FIFO; overrun set beats clear
    always_comb begin
        rx_count_s = rx_wr_q - rx_rd_q;
        rx_valid_s = (rx_wr_q != rx_rd_q);
        rx_full_s  = (rx_count_s == DEPTH_P);
        rx_pop_s   = rx_valid_s && rx_ready;
        rx_push_s  = rx_good_s && (!rx_full_s || rx_pop_s);
        rx_ovf_s   = rx_good_s && rx_full_s && !rx_pop_s;
        rx_wr_d    = rx_wr_q + PW'(rx_push_s);
        rx_rd_d    = rx_rd_q + PW'(rx_pop_s);
        if (rx_ovf_s) begin
            rx_overrun_d = 1'b1;
        end else if (err_clr) begin
            rx_overrun_d = 1'b0;
        end else begin
            rx_overrun_d = rx_overrun_q;
        end
        rts_d = ((DEPTH_P - rx_count_s) <= MARGIN_P);
    end

    // State, pointer and flag registers for both directions
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_wr_q      <= {PW{1'b0}};
            tx_rd_q      <= {PW{1'b0}};
            tx_ready_q   <= 1'b0;
            tx_state_q   <= S_IDLE;
            tx_cnt_q     <= CNT_ZERO;
            tx_bit_q     <= BIT_ZERO;
            tx_shift_q   <= {DATA_BITS{1'b0}};
            tx_line_q    <= 1'b1;
            rx_wr_q      <= {PW{1'b0}};
            rx_rd_q      <= {PW{1'b0}};
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= CNT_ZERO;
            rx_bit_q     <= BIT_ZERO;
            rx_shift_q   <= {DATA_BITS{1'b0}};
            rx_overrun_q <= 1'b0;
            rts_q        <= 1'b1;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q     <= 1'b0;
            rx_perr_q    <= 1'b0;
`endif
        end else begin
            tx_wr_q      <= tx_wr_d;
            tx_rd_q      <= tx_rd_d;
            tx_ready_q   <= tx_ready_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_line_q    <= tx_line_d;
            rx_wr_q      <= rx_wr_d;
            rx_rd_q      <= rx_rd_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_overrun_q <= rx_overrun_d;
            rts_q        <= rts_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
`ifdef UART_PARITY_EN
            tx_par_q     <= tx_par_d;
            rx_perr_q    <= rx_perr_d;
`endif
        end
    end

    // FIFO storage writes (data arrays carry no reset)
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wr_q[AW-1:0]] <= tx_data;
        end
        if (rx_push_s) begin
            rx_mem_q[rx_wr_q[AW-1:0]] <= rx_shift_q;
        end
    end

    assign tx_ready   = tx_ready_q;
    assign rx_valid   = rx_valid_s;
    assign rx_data    = rx_mem_q[rx_rd_q[AW-1:0]];
    assign rx_overrun = rx_overrun_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign uart_tx    = tx_line_q;
    assign uart_rts   = rts_q;

endmodule
